// File: rtl/sdhci_xfer_sequencer.sv
// Block-by-block SD data transfer sequencer: hands single blocks to the data engine,
// gates host buffer access and maintains Block Count. Optional macro: SDHCI_AUTO_CMD12_EN.
module sdhci_xfer_sequencer (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        read_i,
   input  logic        multi_block_i,
   input  logic        block_count_enable_i,
   input  logic        auto_cmd12_enable_i,
   input  logic [15:0] block_count_i,
   input  logic [11:0] block_size_i,
   output logic [11:0] dat_block_size_o,
   output logic        dat_start_o,
   input  logic        dat_done_i,
   input  logic        dat_error_i,
   input  logic        buf_full_i,
   input  logic        buf_empty_i,
   input  logic        stop_i,
   output logic [15:0] block_count_o,
   output logic        block_count_we_o,
   output logic        read_transfer_active_o,
   output logic        write_transfer_active_o,
   output logic        buffer_read_enable_o,
   output logic        buffer_write_enable_o,
   output logic        auto_cmd12_req_o,
   input  logic        auto_cmd12_ack_i,
   output logic        error_o,
   output logic        busy_o
);

   typedef enum logic [2:0] {
      IDLE, WR_BUF, WR_XFER, RD_XFER, RD_BUF, NEXT
`ifdef SDHCI_AUTO_CMD12_EN
      , CMD12
`endif
   } state_t;

   state_t      state_reg;
   logic        dir_reg;
   logic        multi_reg;
   logic        cnt_en_reg;
   logic [15:0] count_reg;
   logic [11:0] bsize_reg;
   logic        last_block;

`ifdef SDHCI_AUTO_CMD12_EN
   logic        acmd_reg;
`else
   logic        unused_cmd12;
   assign unused_cmd12 = auto_cmd12_enable_i ^ auto_cmd12_ack_i;
`endif

   // The latched count already reflects the block just finished when NEXT evaluates it.
   assign last_block = !multi_reg || (cnt_en_reg && count_reg == 16'd0) || stop_i;

   assign busy_o                  = (state_reg != IDLE);
   assign read_transfer_active_o  = (state_reg != IDLE) && dir_reg;
   assign write_transfer_active_o = (state_reg != IDLE) && !dir_reg;
   assign buffer_write_enable_o   = (state_reg == WR_BUF);
   assign buffer_read_enable_o    = (state_reg == RD_BUF);
`ifdef SDHCI_AUTO_CMD12_EN
   assign auto_cmd12_req_o        = (state_reg == CMD12);
`else
   assign auto_cmd12_req_o        = 1'b0;
`endif
   assign block_count_o           = count_reg;
   assign dat_block_size_o        = bsize_reg;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg        <= IDLE;
         dir_reg          <= 1'b0;
         multi_reg        <= 1'b0;
         cnt_en_reg       <= 1'b0;
         count_reg        <= 16'd0;
         bsize_reg        <= 12'd0;
         dat_start_o      <= 1'b0;
         block_count_we_o <= 1'b0;
         error_o          <= 1'b0;
`ifdef SDHCI_AUTO_CMD12_EN
         acmd_reg         <= 1'b0;
`endif
      end else begin
         dat_start_o      <= 1'b0;
         block_count_we_o <= 1'b0;
         error_o          <= 1'b0;
         case (state_reg)
            IDLE: begin
               // A zero count with counting enabled is a no-op transfer.
               if (start_i && !(block_count_enable_i && block_count_i == 16'd0)) begin
                  dir_reg    <= read_i;
                  multi_reg  <= multi_block_i;
                  cnt_en_reg <= block_count_enable_i;
                  count_reg  <= block_count_i;
                  bsize_reg  <= block_size_i;
`ifdef SDHCI_AUTO_CMD12_EN
                  acmd_reg   <= auto_cmd12_enable_i;
`endif
                  if (read_i) begin
                     state_reg   <= RD_XFER;
                     dat_start_o <= 1'b1;
                  end else begin
                     state_reg   <= WR_BUF;
                  end
               end
            end
            WR_BUF: begin
               if (buf_full_i) begin
                  state_reg   <= WR_XFER;
                  dat_start_o <= 1'b1;
               end
            end
            WR_XFER, RD_XFER: begin
               if (dat_done_i) begin
                  if (dat_error_i) begin
                     error_o   <= 1'b1;
                     state_reg <= IDLE;
                  end else begin
                     if (multi_reg && cnt_en_reg && count_reg != 16'd0) begin
                        count_reg        <= count_reg - 16'd1;
                        block_count_we_o <= 1'b1;
                     end
                     state_reg <= (state_reg == RD_XFER) ? RD_BUF : NEXT;
                  end
               end
            end
            RD_BUF: begin
               if (buf_empty_i) state_reg <= NEXT;
            end
            NEXT: begin
               if (!last_block) begin
                  if (dir_reg) begin
                     state_reg   <= RD_XFER;
                     dat_start_o <= 1'b1;
                  end else begin
                     state_reg   <= WR_BUF;
                  end
               end else begin
`ifdef SDHCI_AUTO_CMD12_EN
                  state_reg <= (multi_reg && acmd_reg) ? CMD12 : IDLE;
`else
                  state_reg <= IDLE;
`endif
               end
            end
`ifdef SDHCI_AUTO_CMD12_EN
            CMD12: begin
               if (auto_cmd12_ack_i) state_reg <= IDLE;
            end
`endif
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdhci_xfer_sequencer.sv
// Bench for sdhci_xfer_sequencer: table of transfer scenarios driven by a reactive
// host/data-engine responder, with a scoreboard of expected Block Count writes.
module tb_sdhci_xfer_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, rd, multi, cnt_en, acmd, done, derr, bfull, bempty, stop, ack;
   logic [15:0] bcnt;
   logic [11:0] bsize;
   logic [11:0] dat_block_size_o;
   logic [15:0] block_count_o;
   logic        dat_start_o, block_count_we_o, read_transfer_active_o, write_transfer_active_o;
   logic        buffer_read_enable_o, buffer_write_enable_o, auto_cmd12_req_o, error_o, busy_o;

   sdhci_xfer_sequencer dut (
      .clk_i                   (clk),
      .rst_i                   (rst),
      .start_i                 (start),
      .read_i                  (rd),
      .multi_block_i           (multi),
      .block_count_enable_i    (cnt_en),
      .auto_cmd12_enable_i     (acmd),
      .block_count_i           (bcnt),
      .block_size_i            (bsize),
      .dat_block_size_o        (dat_block_size_o),
      .dat_start_o             (dat_start_o),
      .dat_done_i              (done),
      .dat_error_i             (derr),
      .buf_full_i              (bfull),
      .buf_empty_i             (bempty),
      .stop_i                  (stop),
      .block_count_o           (block_count_o),
      .block_count_we_o        (block_count_we_o),
      .read_transfer_active_o  (read_transfer_active_o),
      .write_transfer_active_o (write_transfer_active_o),
      .buffer_read_enable_o    (buffer_read_enable_o),
      .buffer_write_enable_o   (buffer_write_enable_o),
      .auto_cmd12_req_o        (auto_cmd12_req_o),
      .auto_cmd12_ack_i        (ack),
      .error_o                 (error_o),
      .busy_o                  (busy_o)
   );

   typedef struct {
      bit read, multi, cnt_en, acmd;
      int count, bsize, buf_lat, dat_lat, stop_blk, err_blk;
      int exp_start, exp_we, exp_rdwin, exp_err, exp_fall;
      bit chk_final;
      int exp_final;
   } vec_t;

   vec_t        vecs[9];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   logic [15:0] sb[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic vec_t mk(input bit r, m, ce, ac, input int cnt, bs, bl, dl, sbk, ebk,
                               input int es, ew, erw, ee, ef, input bit cf, input int efin);
      vec_t v;
      v.read = r; v.multi = m; v.cnt_en = ce; v.acmd = ac;
      v.count = cnt; v.bsize = bs; v.buf_lat = bl; v.dat_lat = dl;
      v.stop_blk = sbk; v.err_blk = ebk;
      v.exp_start = es; v.exp_we = ew; v.exp_rdwin = erw; v.exp_err = ee; v.exp_fall = ef;
      v.chk_final = cf; v.exp_final = efin;
      return v;
   endfunction

   task automatic run_vec(input int idx, input vec_t v);
      int n_start = 0, n_we = 0, n_rdwin = 0, n_err = 0, req_n = 0;
      int eng_t = 0, buf_t = 0, trig = -100, end_cyc = 0, fall_cyc = 0, exp_req = 0, fall_d;
      bit prev_act = 1'b0, prev_rd = 1'b0, act, finished = 1'b0;
      logic [15:0] exp_cnt;
`ifdef SDHCI_AUTO_CMD12_EN
      if (v.multi && v.acmd) exp_req = 7;
`endif
      @(negedge clk); cyc++;
      rd = v.read; multi = v.multi; cnt_en = v.cnt_en; acmd = v.acmd;
      bcnt = 16'(v.count); bsize = 12'(v.bsize); start = 1'b1;
      if (v.read) trig = cyc;
      for (int k = 1; k <= v.exp_we; k++) sb.push_back(16'(v.count - k));
      for (int t = 0; t < 5000 && !finished; t++) begin
         @(negedge clk); cyc++;
         start = 1'b0; done = 1'b0; derr = 1'b0; bfull = 1'b0; bempty = 1'b0; ack = 1'b0;
         act = v.read ? read_transfer_active_o : write_transfer_active_o;
         if (t == 0) begin
            chk("busy_after_start", 64'(busy_o), (v.cnt_en && v.count == 0) ? 64'd0 : 64'd1);
            chk("other_dir_active", 64'(v.read ? write_transfer_active_o : read_transfer_active_o), 64'd0);
            if (!(v.cnt_en && v.count == 0))
               chk("block_size", 64'(dat_block_size_o), 64'(v.bsize));
         end
         if (prev_act && !act) fall_cyc = cyc;
         prev_act = act;
         if (block_count_we_o) begin
            n_we++;
            if (sb.size() == 0) chk("unexpected_count_write", 64'(block_count_o), 64'hFFFF_FFFF);
            else begin
               exp_cnt = sb.pop_front();
               chk("block_count_value", 64'(block_count_o), 64'(exp_cnt));
            end
         end
         if (error_o) begin
            n_err++;
            chk("idle_with_error", 64'(busy_o), 64'd0);
         end
         if (!busy_o) finished = 1'b1;
         else begin
            if (dat_start_o) begin
               n_start++;
               chk("dat_start_latency", 64'(cyc), 64'(trig + 1));
               eng_t = v.dat_lat;
            end else if (eng_t > 0) begin
               eng_t--;
               if (eng_t == 0) begin
                  done = 1'b1;
                  derr = (n_start == v.err_blk);
                  if (!v.read || derr) end_cyc = cyc;
               end
            end
            stop = (v.stop_blk != 0 && n_start >= v.stop_blk);
            if (buffer_write_enable_o) begin
               buf_t++;
               if (buf_t >= v.buf_lat) begin bfull = 1'b1; buf_t = 0; trig = cyc; end
            end else if (buffer_read_enable_o) begin
               if (!prev_rd) n_rdwin++;
               buf_t++;
               if (buf_t >= v.buf_lat) begin bempty = 1'b1; buf_t = 0; trig = cyc + 1; end_cyc = cyc; end
            end else buf_t = 0;
            if (auto_cmd12_req_o) begin
               req_n++;
               if (req_n == 7) ack = 1'b1;
            end
         end
         prev_rd = buffer_read_enable_o;
      end
      stop = 1'b0;
      fall_d = (fall_cyc == 0) ? 0 : fall_cyc - end_cyc;
      chk("vec_completes", 64'(finished), 64'd1);
      chk("dat_start_count", 64'(n_start), 64'(v.exp_start));
      chk("count_write_count", 64'(n_we), 64'(v.exp_we));
      chk("read_windows", 64'(n_rdwin), 64'(v.exp_rdwin));
      chk("error_pulses", 64'(n_err), 64'(v.exp_err));
      chk("cmd12_req_cycles", 64'(req_n), 64'(exp_req));
      chk("active_fall_delay", 64'(fall_d), 64'(v.exp_fall + exp_req));
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
      if (v.chk_final) chk("final_count", 64'(block_count_o), 64'(v.exp_final));
      sb.delete();
      $display("vec %0d: %s blocks=%0d count_writes=%0d rd_windows=%0d errors=%0d cmd12_cycles=%0d fall=%0d",
               idx, v.read ? "read " : "write", n_start, n_we, n_rdwin, n_err, req_n, fall_d);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      //            r m ce ac cnt bsz  bl dl stp err | st we rw er fall cf fin
      vecs[0] = mk(0,0,1, 0, 1, 512, 5, 20, 0, 0,   1, 0, 0, 0, 2,   0, 0);
      vecs[1] = mk(1,1,1, 0, 3, 512, 2, 4,  0, 0,   3, 3, 3, 0, 2,   1, 0);
      vecs[2] = mk(0,1,1, 1, 2, 256, 3, 3,  0, 0,   2, 2, 0, 0, 2,   1, 0);
      vecs[3] = mk(1,1,0, 0, 0, 128, 2, 3,  4, 0,   4, 0, 4, 0, 2,   0, 0);
      vecs[4] = mk(0,1,1, 0, 0, 512, 2, 2,  0, 0,   0, 0, 0, 0, 0,   0, 0);
      vecs[5] = mk(1,1,1, 0, 5, 512, 2, 3,  0, 2,   2, 1, 1, 1, 1,   1, 4);
      vecs[6] = mk(0,1,1, 0, 5, 64,  2, 2,  2, 0,   2, 2, 0, 0, 2,   1, 3);
      vecs[7] = mk(0,1,1, 0, 2, 32,  1, 1,  0, 0,   2, 2, 0, 0, 2,   1, 0);
      vecs[8] = mk(1,0,0, 0, 7, 16,  2, 3,  0, 0,   1, 0, 1, 0, 2,   0, 0);

      rst = 1'b1; start = 0; rd = 0; multi = 0; cnt_en = 0; acmd = 0; done = 0; derr = 0;
      bfull = 0; bempty = 0; stop = 0; ack = 0; bcnt = 0; bsize = 0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", 64'({dat_start_o, dat_block_size_o, block_count_o, block_count_we_o,
           read_transfer_active_o, write_transfer_active_o, buffer_read_enable_o,
           buffer_write_enable_o, auto_cmd12_req_o, error_o, busy_o}), 64'd0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

      // Reset while the host is draining a read block.
      @(negedge clk); cyc++;
      rd = 1; multi = 1; cnt_en = 1; acmd = 0; bcnt = 16'd3; bsize = 12'd64; start = 1'b1;
      @(negedge clk); cyc++;
      start = 1'b0;
      chk("rst_seq_dat_start", 64'(dat_start_o), 64'd1);
      done = 1'b1;
      @(negedge clk); cyc++;
      done = 1'b0;
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
         if (buffer_read_enable_o) seen = 1'b1;
         else begin @(negedge clk); cyc++; end
      end
      chk("rst_seq_in_rd_buf", 64'(seen), 64'd1);
      rst = 1'b1;
      @(negedge clk); cyc++;
      chk("mid_xfer_reset_outputs", 64'({dat_start_o, dat_block_size_o, block_count_o, block_count_we_o,
           read_transfer_active_o, write_transfer_active_o, buffer_read_enable_o,
           buffer_write_enable_o, auto_cmd12_req_o, error_o, busy_o}), 64'd0);
      rst = 1'b0;
      $display("reset in RD_BUF: outputs cleared check done");
      run_vec(8, vecs[8]);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sdhci_xfer_sequencer.md
# sdhci_xfer_sequencer

Sequences SD data transfers block by block for the host controller. Given the latched transfer mode, block size and block count, it hands single blocks to the data-line engine and gates host buffer access through the buffer read/write enable flags. It decrements the block count and optionally requests Auto CMD12 at the end of a multi-block transfer. Its outputs drive the Present State and block-count hardware-write inputs of the register logic, which derives transfer-complete and buffer-ready interrupts from them.

## Interface
- No parameters. Block size is passed through; the data engine consumes it.
- `clk_i` in 1: sole clock.
- `rst_i` in 1: synchronous, active-high reset.
- `start_i` in 1: one-cycle pulse; a data command was accepted. Mode inputs are sampled on this cycle.
- `read_i` in 1: direction. 1 = card to host.
- `multi_block_i`, `block_count_enable_i`, `auto_cmd12_enable_i` in 1 each: transfer mode bits.
- `block_count_i` in 16: current Block Count register value.
- `block_size_i` in 12: transfer block size, forwarded as `dat_block_size_o` (out, 12), latched at start.
- `dat_start_o` out 1: one-cycle pulse; transfer one block.
- `dat_done_i` in 1: block finished, one-cycle pulse.
- `dat_error_i` in 1: qualifies `dat_done_i`; the block failed.
- `buf_full_i` in 1: host has written one full block (write direction).
- `buf_empty_i` in 1: host has drained the buffer (read direction).
- `stop_i` in 1: level; stop at the next block boundary.
- `block_count_o` out 16 and `block_count_we_o` out 1: hardware write to Block Count (d/de pair).
- `read_transfer_active_o`, `write_transfer_active_o`, `buffer_read_enable_o`, `buffer_write_enable_o` out 1 each.
- `auto_cmd12_req_o` out 1, `auto_cmd12_ack_i` in 1: level request / one-cycle acknowledge.
- `error_o` out 1: one-cycle pulse on an aborted transfer.
- `busy_o` out 1: state is not IDLE.

## Operation
- States: IDLE, WR_BUF, WR_XFER, RD_XFER, RD_BUF, NEXT, CMD12.
- IDLE to WR_BUF or RD_XFER on `start_i`, according to `read_i`.
  - Exception: `block_count_enable_i`=1 with `block_count_i`=0 means stay in IDLE and do nothing.
  - The latched mode is held until the sequencer returns to IDLE. The latched count is a 16-bit copy.
- WR_BUF: `buffer_write_enable_o`=1. On `buf_full_i`, go to WR_XFER.
- WR_XFER: `dat_start_o` pulses on the entry cycle. On `dat_done_i`, go to NEXT.
- RD_XFER: `dat_start_o` pulses on entry. On `dat_done_i`, go to RD_BUF.
- RD_BUF: `buffer_read_enable_o`=1. On `buf_empty_i`, go to NEXT.
- `*_transfer_active_o` for the latched direction is high in every non-IDLE state. Both are low in IDLE.
- Block count handling, on each error-free `dat_done_i`:
  - Applies only when multi-block mode and count enable are both set.
  - Latched count decrements by 1.
  - `block_count_o` carries the new value and `block_count_we_o`=1 on that same cycle.
  - Count is never decremented below 0.
- NEXT: a single decision cycle.
  - The transfer is last when any of: single-block mode, count enable set and count = 0, or `stop_i`=1.
  - Not last: return to WR_BUF or RD_XFER.
  - Last: go to CMD12 if multi-block and `auto_cmd12_enable_i`; otherwise go to IDLE.
  - With count enable off in multi-block mode, the transfer runs until `stop_i` is seen in NEXT.
- CMD12: `auto_cmd12_req_o`=1 until `auto_cmd12_ack_i`, then go to IDLE.
- Error: `dat_done_i` with `dat_error_i`=1 means:
  - no decrement;
  - `error_o` pulses;
  - go directly to IDLE, with no CMD12.
- `start_i` outside IDLE is ignored.

## Timing
- Reset values: state IDLE, and every output 0, including `block_count_o` and `dat_block_size_o`.
- Any `rst_i` mid-transfer returns to IDLE on the next edge, with outputs 0 from that edge.
- All outputs are registered or decoded from state only; there are no input-to-output combinational paths.
- `dat_start_o` appears 1 cycle after `start_i` for reads, or after `buf_full_i` for writes.
- `block_count_we_o` pulses 1 cycle after `dat_done_i`.
- NEXT costs exactly 1 cycle.
- Active flags drop on the cycle IDLE is entered. That edge is what raises Transfer Complete in the register logic.
- Simultaneous `dat_done_i` and `stop_i`: the block is counted, then the transfer stops in NEXT.
- `buf_full_i` / `buf_empty_i` asserted outside their wait states are ignored (not remembered).

## Configuration
- `SDHCI_AUTO_CMD12_EN` defined: the CMD12 state and request/ack handshake are built as described.
- Not defined:
  - CMD12 state is removed;
  - `auto_cmd12_enable_i` and `auto_cmd12_ack_i` are ignored;
  - `auto_cmd12_req_o` is tied 0;
  - the last block always goes NEXT to IDLE.

## Test plan
- Single-block write, size 512: `start_i`, then `buf_full_i` after 5 cycles, then `dat_done_i` after 20 cycles.
  - Expect one `dat_start_o`.
  - Expect no `block_count_we_o`.
  - `write_transfer_active_o` falls 2 cycles after `dat_done_i`.
- Multi-block read, count 3, count enable set: expect `block_count_o` writes of 2, 1, 0, exactly three `buffer_read_enable_o` windows, then IDLE.
- Multi-block write, count 2, Auto CMD12 enabled (macro on): after the second block, `auto_cmd12_req_o` is held for 7 cycles until ack, then active falls.
  - With the macro off, the same stimulus gives no request.
- Multi-block read with count enable off: `stop_i` raised during block 4 gives exactly 4 blocks, then exit.
- Count enable on with count 0: `start_i` leaves `busy_o`=0 and no `dat_start_o`.
- `dat_error_i` on block 2 of 5: count stays 4, `error_o` pulses once, IDLE next cycle.
- `rst_i` asserted in RD_BUF: all outputs are 0 on the next edge, and a fresh start succeeds.
